// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: fetches two operands from an external 4-entry
// register file, computes one of eight operations and writes the result back.
//
// state | meaning
// IDLE  | ready for a new instruction
// FETCH | capture operands from the register file
// EXEC  | compute result and flags
// WB    | write result to register rd, pulse done
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [1:0]       rd,
    input  logic [1:0]       rs1,
    input  logic [1:0]       rs2,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] wr_data,
    output logic [3:0]       wr_sel,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_opcode;
    logic [1:0]       r_rd;
    logic [1:0]       r_rs1;
    logic [1:0]       r_rs2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        done         = 1'b0;
        wr_sel       = 4'b0000;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: w_next_state = EXEC;
            EXEC:  w_next_state = WB;
            WB: begin
                done         = 1'b1;
                wr_sel       = 4'(4'b0001 << r_rd);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_rs1_val = r0;
        w_rs2_val = r0;
        case (r_rs1)
            2'd0: w_rs1_val = r0;
            2'd1: w_rs1_val = r1;
            2'd2: w_rs1_val = r2;
            default: w_rs1_val = r3;
        endcase
        case (r_rs2)
            2'd0: w_rs2_val = r0;
            2'd1: w_rs2_val = r1;
            2'd2: w_rs2_val = r2;
            default: w_rs2_val = r3;
        endcase
    end

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (r_opcode)
            3'b000: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
            end
            3'b001: begin
                w_result = r_a - r_b;
                w_carry  = (r_a < r_b);
            end
            3'b010: w_result = r_a & r_b;
            3'b011: w_result = r_a | r_b;
            3'b100: w_result = r_a ^ r_b;
            3'b101: w_result = ~r_a;
            3'b110: begin
                w_result = {r_a[WIDTH-2:0], 1'b0};
                w_carry  = r_a[WIDTH-1];
            end
            default: w_result = r_b;
        endcase
    end

    // Fields are captured only on acceptance, so changes while busy are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_opcode <= opcode;
                        r_rd     <= rd;
                        r_rs1    <= rs1;
                        r_rs2    <= rs2;
                    end
                end
                FETCH: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                end
                EXEC: begin
                    r_result <= w_result;
                    r_carry  <= w_carry;
                    r_zero   <= (w_result == '0);
                end
                default: ;
            endcase
        end
    end

    assign busy    = ~instr_ready;
    assign wr_data = r_result;
    assign carry   = r_carry;
    assign zero    = r_zero;

endmodule
